// File: rtl/unary_op_sequencer.sv
// Bit-serial unary operation engine: one single-bit gate slice is stepped
// LSB-first across a WIDTH-bit operand, with valid/ready handshakes on both sides.
module unary_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_NOT, OP_POS, OP_NEG, OP_RAND, OP_ROR, OP_RXOR, OP_RXNOR, OP_LNOT
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               acc_q, acc_d;
  logic               carry_q, carry_d;

  // One-bit datapath slice, evaluated on the current operand LSB.
  logic               bit_a, bit_r, acc_nxt, carry_nxt;
  logic [WIDTH-1:0]   res_shift, final_result;

  always_comb begin
    bit_a     = a_q[0];
    bit_r     = 1'b0;
    acc_nxt   = acc_q;
    carry_nxt = carry_q;
    unique case (op_q)
      OP_NOT:             bit_r = ~bit_a;
      OP_POS:             bit_r = bit_a;
      OP_NEG: begin
        bit_r     = ~bit_a ^ carry_q;
        carry_nxt = ~bit_a & carry_q;
      end
      OP_RAND:            acc_nxt = acc_q & bit_a;
      OP_ROR, OP_LNOT:    acc_nxt = acc_q | bit_a;
      OP_RXOR, OP_RXNOR:  acc_nxt = acc_q ^ bit_a;
      default:            bit_r = 1'b0;
    endcase

    res_shift = {bit_r, res_q[WIDTH-1:1]};
    unique case (op_q)
      OP_NOT, OP_POS, OP_NEG:     final_result = res_shift;
      OP_RXNOR, OP_LNOT:          final_result = {{(WIDTH-1){1'b0}}, ~acc_nxt};
      default:                    final_result = {{(WIDTH-1){1'b0}}, acc_nxt};
    endcase
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    res_d      = res_q;
    out_data_d = out_data_q;
    acc_d      = acc_q;
    carry_d    = carry_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = op_e'(in_op);
          a_d     = in_a;
          cnt_d   = '0;
          res_d   = '0;
          carry_d = 1'b1;
          acc_d   = (op_e'(in_op) == OP_RAND);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        res_d   = res_shift;
        acc_d   = acc_nxt;
        carry_d = carry_nxt;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          cnt_d      = '0;
          out_data_d = final_result;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOT;
      cnt_q      <= '0;
      a_q        <= '0;
      res_q      <= '0;
      out_data_q <= '0;
      acc_q      <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      res_q      <= res_d;
      out_data_q <= out_data_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_unary_op_sequencer.sv
// Self-checking bench for unary_op_sequencer: directed vector table, multi-cycle
// corner sequences and randomized operations against an arithmetic reference model.
module tb_unary_op_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  unary_op_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Whole-word reference: the operation as plain arithmetic/reduction operators.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a);
    logic [W-1:0] r;
    case (op)
      3'd0: r = ~a;
      3'd1: r = a;
      3'd2: r = W'(0) - a;
      3'd3: r = {{(W-1){1'b0}}, &a};
      3'd4: r = {{(W-1){1'b0}}, |a};
      3'd5: r = {{(W-1){1'b0}}, ^a};
      3'd6: r = {{(W-1){1'b0}}, ~^a};
      default: r = {{(W-1){1'b0}}, (a == '0)};
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents one request for a single accept edge.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    tick();
    in_valid = 1'b0;
    in_op    = 3'($urandom);
    in_a     = W'($urandom);
  endtask

  // Counts cycles from accept to out_valid; in_ready must stay low throughout.
  task automatic wait_done(output int cycles);
    bit ready_seen = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      cycles++;
    end
    check("busy_in_ready", int'(ready_seen | in_ready), 0);
    if (!out_valid) check("done_timeout", 0, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_out_valid", int'(out_valid), 0);
    check("post_hs_in_ready", int'(in_ready), 1);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] exp);
    int cyc;
    start_op(op, a);
    wait_done(cyc);
    check({name, "_latency"}, cyc, W);
    check(name, int'(out_data), int'(exp));
    handshake();
  endtask

  vec_t vecs[$];
  int   acc_times[$];
  logic [W-1:0] exp_q[$];

  initial begin
    int cyc;
    logic [W-1:0] held;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);

    vecs = '{
      '{3'd2, 8'h01, 8'hFF}, '{3'd2, 8'h80, 8'h80}, '{3'd2, 8'h00, 8'h00},
      '{3'd0, 8'hA5, 8'h5A}, '{3'd1, 8'h3C, 8'h3C},
      '{3'd3, 8'hFF, 8'h01}, '{3'd4, 8'hFF, 8'h01}, '{3'd5, 8'hFF, 8'h00},
      '{3'd6, 8'hFF, 8'h01}, '{3'd7, 8'hFF, 8'h00},
      '{3'd3, 8'h00, 8'h00}, '{3'd4, 8'h00, 8'h00}, '{3'd7, 8'h00, 8'h01},
      '{3'd5, 8'h07, 8'h01}, '{3'd6, 8'h07, 8'h00}, '{3'd2, 8'h06, 8'hFA}
    };
    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].exp);

    // Backpressure: DONE holds while a competing request waits.
    start_op(3'd0, 8'h0F);
    wait_done(cyc);
    held     = out_data;
    check("bp_first", int'(held), 8'hF0);
    in_valid = 1'b1; in_op = 3'd1; in_a = 8'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_data", int'(out_data), int'(held));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_in_ready", int'(in_ready), 1);
    check("bp_hs_out_data", int'(out_data), int'(held));
    tick();
    in_valid = 1'b0;
    check("bp_accepted", int'(in_ready), 0);
    wait_done(cyc);
    check("bp_second_latency", cyc, W);
    check("bp_second", int'(out_data), 8'h99);
    handshake();

    // Reset abort during RUN cycle 3.
    start_op(3'd2, 8'h01);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_data", int'(out_data), 0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
        if (out_valid) seen = 1'b1;
        tick();
      end
      check("abort_no_result", int'(seen), 0);
    end

    // Back-to-back alternating NEG/RXOR with both handshakes tied high.
    begin
      int k = 0;
      bit adv = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      in_op = 3'd2; in_a = W'($urandom);
      for (int t = 0; t < 80; t++) begin
        if (in_ready && in_valid) begin
          acc_times.push_back(t);
          exp_q.push_back(model(in_op, in_a));
          adv = 1'b1;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) check("b2b_spurious", 1, 0);
          else check("b2b_result", int'(out_data), int'(exp_q.pop_front()));
        end
        tick();
        if (adv) begin
          adv = 1'b0;
          k++;
          in_op = (k % 2 == 0) ? 3'd2 : 3'd5;
          in_a  = W'($urandom);
          if (k == 6) in_valid = 1'b0;
        end
      end
      out_ready = 1'b0;
      check("b2b_count", acc_times.size(), 6);
      check("b2b_drained", exp_q.size(), 0);
      for (int i = 1; i < acc_times.size(); i++)
        check("b2b_interval", acc_times[i] - acc_times[i-1], W + 2);
    end

    // Randomized operations against the reference model, with random output stalls.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a;
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      start_op(op, a);
      wait_done(cyc);
      check("rand_latency", cyc, W);
      repeat ($urandom_range(0, 3)) tick();
      check($sformatf("rand_op%0d_a%0h", op, a), int'(out_data), int'(model(op, a)));
      handshake();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
